// File: rtl/decode_ctrl_stage.sv
// RV32I decode/control stage behind a 2-entry skid buffer (registered outputs, 1-cycle latency).
// Optional macro DECODE_ILLEGAL_TRAP_EN: flag unknown opcodes via illegal_o instead of decoding them as a NOP.
module decode_ctrl_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [2:0]  aluop_o,
    output logic [2:0]  func3_o,
    output logic        func7_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        illegal_o
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic [2:0] func3;
        logic       func7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mem_read;
        logic       mem_write;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } dec_t;

    state_t state_q, state_d;
    dec_t   dec, out_q, skid_q;
    logic   in_fire, out_fire;
    logic   load_out, load_skid, out_from_skid;

    // Funct7 bits other than instr[30] carry no ALU control information.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_i[31], instr_i[29:25]};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        dec     = '0;
        dec.rs1 = instr_i[19:15];
        dec.rs2 = instr_i[24:20];
        dec.rd  = instr_i[11:7];
        case (instr_i[6:0])
            7'b0110011: begin
                dec.aluop = 3'b000;
                dec.func3 = instr_i[14:12];
                dec.func7 = instr_i[30];
            end
            7'b0010011: begin
                dec.aluop = 3'b001;
                dec.func3 = instr_i[14:12];
                // Only the shift-right immediates use instr[30] to pick SRAI over SRLI.
                dec.func7 = (instr_i[14:12] == 3'b101) ? instr_i[30] : 1'b0;
            end
            7'b1100011: begin
                dec.aluop = 3'b010;
                dec.func3 = instr_i[14:12];
            end
            7'b1101111, 7'b1100111: dec.aluop = 3'b011;
            7'b0000011: begin
                dec.aluop    = 3'b100;
                dec.mem_read = 1'b1;
            end
            7'b0100011: begin
                dec.aluop     = 3'b101;
                dec.mem_write = 1'b1;
            end
            7'b0110111, 7'b0010111: dec.aluop = 3'b110;
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                dec.aluop   = 3'b111;
                dec.illegal = 1'b1;
`else
                dec.aluop = 3'b001;
                dec.rd    = 5'd0;
`endif
            end
        endcase
    end

    assign instr_ready_o = (state_q != FULL);
    assign dec_valid_o   = (state_q != EMPTY);
    assign in_fire       = instr_valid_i && instr_ready_o;
    assign out_fire      = dec_valid_o && dec_ready_i;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (out_fire && !in_fire) begin
                    state_d = EMPTY;
                end else if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d       = ONE;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any same-cycle transfer; the incoming word is dropped.
        if (flush_i) begin
            state_d   = EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
        end
    end

    // NOTE: the two entry registers are cleared on reset so every output reads 0 until the first transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out)  out_q  <= out_from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign aluop_o     = out_q.aluop;
    assign func3_o     = out_q.func3;
    assign func7_o     = out_q.func7;
    assign rs1_o       = out_q.rs1;
    assign rs2_o       = out_q.rs2;
    assign rd_o        = out_q.rd;
    assign mem_read_o  = out_q.mem_read;
    assign mem_write_o = out_q.mem_write;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal_o   = out_q.illegal;
`else
    assign illegal_o   = 1'b0;
`endif

endmodule
